// File: rtl/pico_mem_router_pkg.sv
// Shared types and constants for the PicoRV32 memory router and its decoder.
package pico_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BRAM = 2'd1,
    MMIO = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BRAM = 2'd1,
    SEL_MMIO = 2'd2
  } sel_t;

  localparam logic [31:0] C_ERR_RDATA_DEF = 32'hDEAD_BEEF;
  localparam int          C_ERR_CNT_W     = 8;

  // Error counter holds at all-ones instead of wrapping.
  function automatic logic [C_ERR_CNT_W-1:0] err_cnt_inc(input logic [C_ERR_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/pico_mem_router_if.sv
// PicoRV32-style valid/ready memory bus; master issues requests, slave completes them.
interface pico_mem_router_if;
  logic        VALID;
  logic        INSTR;
  logic        READY;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic [31:0] RDATA;

  modport master (
    output VALID, INSTR, ADDR, WDATA, WSTRB,
    input  READY, RDATA
  );

  modport slave (
    input  VALID, INSTR, ADDR, WDATA, WSTRB,
    output READY, RDATA
  );
endinterface

// File: rtl/pico_mem_router_decode.sv
// Combinational base/mask region decoder; BRAM has priority on overlapping regions.
module pico_mem_decode
  import pico_mem_pkg::*;
#(
  parameter logic [31:0] C_BRAM_BASE = 32'h0000_0000,
  parameter logic [31:0] C_BRAM_MASK = 32'hFFFF_0000,
  parameter logic [31:0] C_MMIO_BASE = 32'h4000_0000,
  parameter logic [31:0] C_MMIO_MASK = 32'hF000_0000
) (
  input  logic [31:0] i_addr,
  output sel_t        o_sel
);

  logic w_bram_hit;
  logic w_mmio_hit;

  assign w_bram_hit = ((i_addr & C_BRAM_MASK) == C_BRAM_BASE);
  assign w_mmio_hit = ((i_addr & C_MMIO_MASK) == C_MMIO_BASE);

  always_comb begin
    o_sel = SEL_NONE;
    if (w_bram_hit) begin
      o_sel = SEL_BRAM;
    end else if (w_mmio_hit) begin
      o_sel = SEL_MMIO;
    end
  end

endmodule

// File: rtl/pico_mem_router.sv
// Registers each core request, forwards it to BRAM or MMIO, and answers
// unmapped or stalled accesses with an error word plus a sticky error log.
module pico_mem_router
  import pico_mem_pkg::*;
#(
  parameter logic [31:0] C_BRAM_BASE = 32'h0000_0000,
  parameter logic [31:0] C_BRAM_MASK = 32'hFFFF_0000,
  parameter logic [31:0] C_MMIO_BASE = 32'h4000_0000,
  parameter logic [31:0] C_MMIO_MASK = 32'hF000_0000,
  parameter int unsigned C_TIMEOUT   = 16,
  parameter logic [31:0] C_ERR_RDATA = C_ERR_RDATA_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  pico_mem_router_if.slave       mem,
  pico_mem_router_if.master      bram,
  pico_mem_router_if.master      mmio,
  output logic                   ERR_VALID,
  output logic [31:0]            ERR_ADDR,
  output logic                   ERR_INSTR,
  output logic [C_ERR_CNT_W-1:0] ERR_COUNT
);

  localparam int C_CNT_W = $clog2(C_TIMEOUT + 1);

  state_t                 r_state;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic [3:0]             r_wstrb;
  logic                   r_instr;
  logic [31:0]            r_rdata;
  logic                   r_err;
  logic [C_CNT_W-1:0]     r_cnt;
  logic [31:0]            r_err_addr;
  logic                   r_err_instr;
  logic [C_ERR_CNT_W-1:0] r_err_count;

  state_t      w_state_next;
  sel_t        w_sel;
  logic        w_latch;
  logic        w_to_resp;
  logic        w_fail;
  logic [31:0] w_rdata_next;
  logic [31:0] w_err_addr;
  logic        w_err_instr;
  logic        w_expired;

  pico_mem_decode #(
    .C_BRAM_BASE (C_BRAM_BASE),
    .C_BRAM_MASK (C_BRAM_MASK),
    .C_MMIO_BASE (C_MMIO_BASE),
    .C_MMIO_MASK (C_MMIO_MASK)
  ) u_decode (
    .i_addr (mem.ADDR),
    .o_sel  (w_sel)
  );

  // Last waiting cycle: counter would reach C_TIMEOUT on this edge.
  assign w_expired = (r_cnt == C_CNT_W'(C_TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_to_resp    = 1'b0;
    w_fail       = 1'b0;
    w_rdata_next = r_rdata;
    w_err_addr   = r_addr;
    w_err_instr  = r_instr;
    case (r_state)
      IDLE: begin
        if (mem.VALID) begin
          w_latch = 1'b1;
          case (w_sel)
            SEL_BRAM: w_state_next = BRAM;
            SEL_MMIO: w_state_next = MMIO;
            default: begin
              w_state_next = RESP;
              w_to_resp    = 1'b1;
              w_fail       = 1'b1;
              w_rdata_next = C_ERR_RDATA;
              w_err_addr   = mem.ADDR;
              w_err_instr  = mem.INSTR;
            end
          endcase
        end
      end
      BRAM: begin
        if (bram.READY) begin
          w_state_next = RESP;
          w_to_resp    = 1'b1;
          w_rdata_next = bram.RDATA;
        end else if (w_expired) begin
          w_state_next = RESP;
          w_to_resp    = 1'b1;
          w_fail       = 1'b1;
          w_rdata_next = C_ERR_RDATA;
        end
      end
      MMIO: begin
        if (mmio.READY) begin
          w_state_next = RESP;
          w_to_resp    = 1'b1;
          w_rdata_next = mmio.RDATA;
        end else if (w_expired) begin
          w_state_next = RESP;
          w_to_resp    = 1'b1;
          w_fail       = 1'b1;
          w_rdata_next = C_ERR_RDATA;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_instr     <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_err_addr  <= '0;
      r_err_instr <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_addr  <= mem.ADDR;
        r_wdata <= mem.WDATA;
        r_wstrb <= mem.WSTRB;
        r_instr <= mem.INSTR;
      end
      if (w_to_resp) begin
        r_rdata <= w_rdata_next;
        r_err   <= w_fail;
      end
      if ((r_state == BRAM || r_state == MMIO) && !w_to_resp) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      // Log is written on entry to RESP so it is visible alongside ERR_VALID.
      if (w_fail) begin
        r_err_addr  <= w_err_addr;
        r_err_instr <= w_err_instr;
        r_err_count <= err_cnt_inc(r_err_count);
      end
    end
  end

  assign bram.VALID = (r_state == BRAM);
  assign bram.ADDR  = r_addr;
  assign bram.WDATA = r_wdata;
  assign bram.WSTRB = r_wstrb;
  assign bram.INSTR = r_instr & (r_state == BRAM);

  assign mmio.VALID = (r_state == MMIO);
  assign mmio.ADDR  = r_addr;
  assign mmio.WDATA = r_wdata;
  assign mmio.WSTRB = r_wstrb;
  assign mmio.INSTR = r_instr & (r_state == MMIO);

  assign mem.READY  = (r_state == RESP);
  assign mem.RDATA  = (r_state == RESP) ? r_rdata : 32'h0;

  assign ERR_VALID  = (r_state == RESP) && r_err;
  assign ERR_ADDR   = r_err_addr;
  assign ERR_INSTR  = r_err_instr;
  assign ERR_COUNT  = r_err_count;

endmodule

// File: tb/tb_pico_mem_router.sv
// Scoreboard bench for pico_mem_router: stimulus pushes expected responses,
// a negedge monitor pops and compares on every MEM_READY pulse.
module tb_pico_mem_router;
  import pico_mem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
    logic        einstr;
    logic [7:0]  ecount;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ERR_VALID;
  logic [31:0] ERR_ADDR;
  logic        ERR_INSTR;
  logic [7:0]  ERR_COUNT;

  pico_mem_router_if mem_if ();
  pico_mem_router_if bram_if ();
  pico_mem_router_if mmio_if ();

  pico_mem_router dut (
    .CLK       (CLK),
    .RST       (RST),
    .mem       (mem_if),
    .bram      (bram_if),
    .mmio      (mmio_if),
    .ERR_VALID (ERR_VALID),
    .ERR_ADDR  (ERR_ADDR),
    .ERR_INSTR (ERR_INSTR),
    .ERR_COUNT (ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   ready_pulses = 0;
  logic [7:0] exp_errcnt = 8'd0;

  // Slave model controls and observations
  int          b_delay = 1, m_delay = 1;
  logic [31:0] b_data = 32'h0, m_data = 32'h0;
  logic        b_force = 1'b0, m_force = 1'b0;
  int          b_cnt = 0, m_cnt = 0;
  int          bram_vcycles = 0, mmio_vcycles = 0;
  int          stab_err = 0;
  logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;
  logic [3:0]  cur_wstrb = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each completion pulse
  always @(negedge CLK) begin
    exp_t e;
    if (RST !== 1'b1) begin
      if (mem_if.READY === 1'b1) begin
        ready_pulses++;
        if (sb.size() == 0) begin
          chk("unexpected_mem_ready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("mem_rdata", mem_if.RDATA, e.rdata);
          chk("err_valid", {31'd0, ERR_VALID}, {31'd0, e.err});
          if (e.err) begin
            chk("err_addr", ERR_ADDR, e.eaddr);
            chk("err_instr", {31'd0, ERR_INSTR}, {31'd0, e.einstr});
          end
          chk("err_count", {24'd0, ERR_COUNT}, {24'd0, e.ecount});
        end
      end else begin
        chk("rdata_idle_zero", mem_if.RDATA, 32'h0);
        chk("err_valid_idle", {31'd0, ERR_VALID}, 32'd0);
      end
    end
  end

  // BRAM slave: READY b_delay cycles after VALID first appears (-1 = never)
  initial begin
    bram_if.READY = 1'b0;
    bram_if.RDATA = 32'h0;
    forever begin
      @(posedge CLK); #2;
      if (bram_if.VALID === 1'b1) begin
        b_cnt++;
        bram_vcycles++;
        if (bram_if.ADDR !== cur_addr || bram_if.WDATA !== cur_wdata || bram_if.WSTRB !== cur_wstrb)
          stab_err++;
        bram_if.READY = (b_delay >= 0 && b_cnt > b_delay);
        bram_if.RDATA = bram_if.READY ? b_data : 32'h0;
      end else begin
        b_cnt = 0;
        bram_if.READY = b_force;
        bram_if.RDATA = b_force ? b_data : 32'h0;
      end
    end
  end

  initial begin
    mmio_if.READY = 1'b0;
    mmio_if.RDATA = 32'h0;
    forever begin
      @(posedge CLK); #2;
      if (mmio_if.VALID === 1'b1) begin
        m_cnt++;
        mmio_vcycles++;
        if (mmio_if.ADDR !== cur_addr || mmio_if.WDATA !== cur_wdata || mmio_if.WSTRB !== cur_wstrb)
          stab_err++;
        mmio_if.READY = (m_delay >= 0 && m_cnt > m_delay);
        mmio_if.RDATA = mmio_if.READY ? m_data : 32'h0;
      end else begin
        m_cnt = 0;
        mmio_if.READY = m_force;
        mmio_if.RDATA = m_force ? m_data : 32'h0;
      end
    end
  end

  // Issue one request, push its expected response, return cycles to MEM_READY
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic ins, input logic [31:0] exp_rd, input logic exp_err,
                       output int lat);
    exp_t e;
    if (exp_err && exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
    e.rdata = exp_rd; e.err = exp_err; e.eaddr = a; e.einstr = ins; e.ecount = exp_errcnt;
    sb.push_back(e);
    cur_addr = a; cur_wdata = wd; cur_wstrb = ws;
    @(posedge CLK); #1;
    mem_if.VALID = 1'b1; mem_if.ADDR = a; mem_if.WDATA = wd;
    mem_if.WSTRB = ws;   mem_if.INSTR = ins;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (mem_if.READY === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk("mem_ready_wait_expired", 32'd1, 32'd0);
    @(posedge CLK); #1;
    mem_if.VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int pulses0;
    RST = 1'b1;
    mem_if.VALID = 1'b0; mem_if.INSTR = 1'b0; mem_if.ADDR = 32'h0;
    mem_if.WDATA = 32'h0; mem_if.WSTRB = 4'h0;
    repeat (3) @(posedge CLK);
    #3;
    chk("rst_mem_ready", {31'd0, mem_if.READY}, 32'd0);
    chk("rst_mem_rdata", mem_if.RDATA, 32'h0);
    chk("rst_bram_valid", {31'd0, bram_if.VALID}, 32'd0);
    chk("rst_mmio_valid", {31'd0, mmio_if.VALID}, 32'd0);
    chk("rst_bram_addr", bram_if.ADDR, 32'h0);
    chk("rst_err", {ERR_ADDR[30:0], ERR_VALID}, 32'd0);
    chk("rst_err_count", {23'd0, ERR_INSTR, ERR_COUNT}, 32'd0);
    @(negedge CLK); RST = 1'b0;

    // BRAM read, one-cycle slave
    b_delay = 1; b_data = 32'h1234_5678; bram_vcycles = 0; mmio_vcycles = 0; stab_err = 0;
    issue(32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b0, lat);
    chk("bram_rd_latency", lat, 3);
    chk("bram_rd_valid_cycles", bram_vcycles, 2);
    chk("bram_rd_mmio_idle", mmio_vcycles, 0);
    chk("bram_rd_stable", stab_err, 0);

    // MMIO write, READY on the fifth VALID cycle
    m_delay = 4; m_data = 32'h0; bram_vcycles = 0; mmio_vcycles = 0; stab_err = 0;
    pulses0 = ready_pulses;
    issue(32'h4000_0010, 32'hA5A5_A5A5, 4'b0011, 1'b0, 32'h0, 1'b0, lat);
    chk("mmio_wr_latency", lat, 6);
    chk("mmio_wr_valid_cycles", mmio_vcycles, 5);
    chk("mmio_wr_stable", stab_err, 0);
    chk("mmio_wr_bram_idle", bram_vcycles, 0);
    chk("mmio_wr_pulses", ready_pulses - pulses0, 1);
    chk("mmio_wr_err_count", {24'd0, ERR_COUNT}, 32'd0);

    // Unmapped instruction fetch
    bram_vcycles = 0; mmio_vcycles = 0;
    issue(32'h8000_0000, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, lat);
    chk("unmapped_latency", lat, 1);
    chk("unmapped_no_downstream", bram_vcycles + mmio_vcycles, 0);
    chk("unmapped_err_count", {24'd0, ERR_COUNT}, 32'd1);

    // MMIO read that never completes, then a late READY
    m_delay = -1; m_data = 32'hCAFE_F00D; mmio_vcycles = 0;
    pulses0 = ready_pulses;
    issue(32'h4000_0020, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, lat);
    chk("timeout_latency", lat, 17);
    chk("timeout_valid_cycles", mmio_vcycles, 16);
    chk("timeout_err_count", {24'd0, ERR_COUNT}, 32'd2);
    @(posedge CLK); #3;
    m_force = 1'b1;
    @(posedge CLK); #3;
    m_force = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("late_ready_ignored", ready_pulses - pulses0, 1);
    chk("late_ready_mmio_idle", {31'd0, mmio_if.VALID}, 32'd0);

    // Asynchronous reset while BRAM request is outstanding
    b_delay = -1;
    @(posedge CLK); #1;
    mem_if.VALID = 1'b1; mem_if.ADDR = 32'h0000_0200; mem_if.WSTRB = 4'h0; mem_if.INSTR = 1'b0;
    @(posedge CLK); #1;
    chk("pre_rst_bram_valid", {31'd0, bram_if.VALID}, 32'd1);
    #2; RST = 1'b1; mem_if.VALID = 1'b0;
    #1;
    chk("async_rst_bram_valid", {31'd0, bram_if.VALID}, 32'd0);
    chk("async_rst_mem_ready", {31'd0, mem_if.READY}, 32'd0);
    chk("async_rst_err_count", {24'd0, ERR_COUNT}, 32'd0);
    exp_errcnt = 8'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    b_delay = 1; b_data = 32'h0BAD_F00D;
    issue(32'h0000_0300, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D, 1'b0, lat);
    chk("post_rst_latency", lat, 3);

    // Back-to-back unmapped accesses saturate the error counter
    pulses0 = ready_pulses;
    for (int i = 0; i < 300; i++) begin
      issue(32'h8000_0000 + 32'(i * 4), 32'h0, 4'(i & 1), i[0], 32'hDEAD_BEEF, 1'b1, lat);
      if (lat != 1) chk("sat_latency", lat, 1);
    end
    chk("sat_pulses", ready_pulses - pulses0, 300);
    chk("sat_err_count", {24'd0, ERR_COUNT}, 32'd255);
    repeat (3) @(posedge CLK);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
